pe_feeder: RTL and testbench

Operand transmitter sitting in front of a PE: drives the PE's `Input` and `Weight` rdy/ack receive channels from two upstream source streams under a per-job command. A job declares how many weight vectors (PECOL words each) and input vectors (IPADN words each) to forward. The block meters them through one-entry register slices and pulses `o_done` when the last vector has been accepted by the PE. It is the sending end of the PE's Input/Weight protocol.

---
 rtl/pe_feeder_pkg.sv | 37 +++
 rtl/rdyack_slice.sv | 46 ++++
 rtl/pe_feeder.sv | 203 ++++++++++++++++++++
 tb/tb_pe_feeder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_feeder_pkg.sv
// Shared configuration for the PE operand feeder.
//   PECfg    : datapath geometry defaults (word width, vector lengths).
//   PECtlCfg : job command layout and feeder FSM state encoding.
// The RUN state only exists when PE_FEEDER_OVERLAP_EN is defined.

package PECfg;
    localparam int DWD   = 16;  // data word width
    localparam int IPADN = 3;   // words per Input vector
    localparam int PECOL = 4;   // words per Weight vector
endpackage

package PECtlCfg;
    localparam int CNTW = 8;    // job count width

    // Job command: nw in the upper half, ni in the lower half.
    typedef struct packed {
        logic [CNTW-1:0] nw;
        logic [CNTW-1:0] ni;
    } FeedCmd;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WLOAD = 3'd1,
        ILOAD = 3'd2,
        DONE  = 3'd3
`ifdef PE_FEEDER_OVERLAP_EN
        ,
        RUN   = 3'd4
`endif
    } feed_state_e;

    // A phase is finished once every vector has been taken from the source
    // and its slice is either empty or handing its last entry to the PE now.
    function automatic logic phase_finished(input logic more, input logic slice_free);
        return !more && slice_free;
    endfunction
endpackage

// File: rtl/rdyack_slice.sv
// One-entry register slice on a rdy/ack channel.
//   i_clk, i_rst : clock, asynchronous active-high reset (discards the entry)
//   i_load       : write i_data into the slice this cycle (upstream transfer)
//   i_data       : vector to store, NW words of DWD bits
//   o_rdy        : slice holds a vector for the downstream side
//   i_ack        : downstream accepts; a transfer happens when o_rdy && i_ack
//   o_data       : stored vector, stable while o_rdy && !i_ack
//   o_free       : slice can take a new vector this cycle (empty, or draining now)

module rdyack_slice #(
    parameter int DWD = 16,
    parameter int NW  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [DWD*NW-1:0] i_data,
    output logic              o_rdy,
    input  logic              i_ack,
    output logic [DWD*NW-1:0] o_data,
    output logic              o_free
);

    logic              full;
    logic [DWD*NW-1:0] data_q;

    assign o_rdy  = full;
    assign o_data = data_q;
    // Draining and reloading in the same cycle keeps o_rdy high, giving
    // one vector per cycle when the downstream holds ack.
    assign o_free = !full || i_ack;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            full   <= 1'b0;
            data_q <= '0;
        end else if (i_load) begin
            full   <= 1'b1;
            data_q <= i_data;
        end else if (i_ack) begin
            // ack while empty is harmless: full is already 0
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Operand transmitter in front of a PE. Accepts a job command {nw, ni},
// forwards nw Weight vectors and ni Input vectors from the source streams
// to the PE through one-entry slices, and pulses o_done when the PE has
// taken the last vector.
//
// Build option: PE_FEEDER_OVERLAP_EN -- when defined, both channels run
// concurrently in a single RUN state; otherwise weights are sent first,
// then inputs.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   Cmd_rdy/Cmd_ack, i_cmd  job command channel ({nw, ni}, FeedCmd layout)
//   SrcW_rdy/SrcW_ack, i_SrcW   weight source channel
//   SrcI_rdy/SrcI_ack, i_SrcI   input source channel
//   Weight_rdy/Weight_ack, o_Weight  PE weight channel
//   Input_rdy/Input_ack, o_Input     PE input channel
//   o_busy                  job in progress (state not IDLE)
//   o_done                  one-cycle job-complete pulse

module pe_feeder
    import PECtlCfg::*;
#(
    parameter int DWD   = PECfg::DWD,
    parameter int IPADN = PECfg::IPADN,
    parameter int PECOL = PECfg::PECOL,
    parameter int CNTW  = PECtlCfg::CNTW
) (
    input  logic                 i_clk,
    input  logic                 i_rst,

    input  logic                 Cmd_rdy,
    output logic                 Cmd_ack,
    input  logic [2*CNTW-1:0]    i_cmd,

    input  logic                 SrcW_rdy,
    output logic                 SrcW_ack,
    input  logic [DWD*PECOL-1:0] i_SrcW,

    input  logic                 SrcI_rdy,
    output logic                 SrcI_ack,
    input  logic [DWD*IPADN-1:0] i_SrcI,

    output logic                 Weight_rdy,
    input  logic                 Weight_ack,
    output logic [DWD*PECOL-1:0] o_Weight,

    output logic                 Input_rdy,
    input  logic                 Input_ack,
    output logic [DWD*IPADN-1:0] o_Input,

    output logic                 o_busy,
    output logic                 o_done
);

    feed_state_e     state, state_nx;
    logic [CNTW-1:0] nw_q, ni_q;
    logic [CNTW-1:0] wcnt, icnt;
    logic [CNTW-1:0] cmd_nw, cmd_ni;

    logic cmd_xfer;
    logic w_load, i_load;
    logic w_free, i_free;
    logic w_more, i_more;

    // Same bit layout as FeedCmd, taken with this instance's CNTW.
    assign cmd_nw = i_cmd[2*CNTW-1:CNTW];
    assign cmd_ni = i_cmd[CNTW-1:0];

    assign cmd_xfer = Cmd_rdy && Cmd_ack;
    assign w_load   = SrcW_rdy && SrcW_ack;
    assign i_load   = SrcI_rdy && SrcI_ack;

    // Counts stop exactly at the job length; with nw,ni <= 2^CNTW-1 the
    // counters never wrap.
    assign w_more = (wcnt < nw_q);
    assign i_more = (icnt < ni_q);

    assign o_busy = (state != IDLE);

    rdyack_slice #(
        .DWD (DWD),
        .NW  (PECOL)
    ) u_wslice (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_data (i_SrcW),
        .o_rdy  (Weight_rdy),
        .i_ack  (Weight_ack),
        .o_data (o_Weight),
        .o_free (w_free)
    );

    rdyack_slice #(
        .DWD (DWD),
        .NW  (IPADN)
    ) u_islice (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (i_load),
        .i_data (i_SrcI),
        .o_rdy  (Input_rdy),
        .i_ack  (Input_ack),
        .o_data (o_Input),
        .o_free (i_free)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            nw_q <= '0;
            ni_q <= '0;
            wcnt <= '0;
            icnt <= '0;
        end else if (cmd_xfer) begin
            nw_q <= cmd_nw;
            ni_q <= cmd_ni;
            wcnt <= '0;
            icnt <= '0;
        end else begin
            if (w_load) begin
                wcnt <= wcnt + 1'b1;
            end
            if (i_load) begin
                icnt <= icnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        Cmd_ack  = 1'b0;
        SrcW_ack = 1'b0;
        SrcI_ack = 1'b0;
        o_done   = 1'b0;

        case (state)
            IDLE: begin
                Cmd_ack = 1'b1;
                if (Cmd_rdy) begin
`ifdef PE_FEEDER_OVERLAP_EN
                    if ((cmd_nw != '0) || (cmd_ni != '0)) begin
                        state_nx = RUN;
                    end else begin
                        state_nx = DONE;
                    end
`else
                    if (cmd_nw != '0) begin
                        state_nx = WLOAD;
                    end else if (cmd_ni != '0) begin
                        state_nx = ILOAD;
                    end else begin
                        state_nx = DONE;
                    end
`endif
                end
            end

`ifdef PE_FEEDER_OVERLAP_EN
            RUN: begin
                SrcW_ack = w_more && w_free;
                SrcI_ack = i_more && i_free;
                if (phase_finished(w_more, w_free) && phase_finished(i_more, i_free)) begin
                    state_nx = DONE;
                end
            end
`else
            WLOAD: begin
                SrcW_ack = w_more && w_free;
                // Leaving while the last PE transfer happens puts o_done
                // one cycle after it.
                if (phase_finished(w_more, w_free)) begin
                    state_nx = (ni_q != '0) ? ILOAD : DONE;
                end
            end

            ILOAD: begin
                SrcI_ack = i_more && i_free;
                if (phase_finished(i_more, i_free)) begin
                    state_nx = DONE;
                end
            end
`endif

            DONE: begin
                o_done   = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: per-cycle table of inputs and expected
// outputs for full jobs, plus hand-written reset-abort and restart sequences.

module tb_pe_feeder;
    import PECtlCfg::*;

    localparam int DWD   = 16;
    localparam int IPADN = 3;
    localparam int PECOL = 4;
    localparam int CNTW  = 8;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 Cmd_rdy;
    logic                 Cmd_ack;
    logic [2*CNTW-1:0]    i_cmd;
    logic                 SrcW_rdy;
    logic                 SrcW_ack;
    logic [DWD*PECOL-1:0] i_SrcW;
    logic                 SrcI_rdy;
    logic                 SrcI_ack;
    logic [DWD*IPADN-1:0] i_SrcI;
    logic                 Weight_rdy;
    logic                 Weight_ack;
    logic [DWD*PECOL-1:0] o_Weight;
    logic                 Input_rdy;
    logic                 Input_ack;
    logic [DWD*IPADN-1:0] o_Input;
    logic                 o_busy;
    logic                 o_done;

    pe_feeder #(
        .DWD   (DWD),
        .IPADN (IPADN),
        .PECOL (PECOL),
        .CNTW  (CNTW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .Cmd_rdy    (Cmd_rdy),
        .Cmd_ack    (Cmd_ack),
        .i_cmd      (i_cmd),
        .SrcW_rdy   (SrcW_rdy),
        .SrcW_ack   (SrcW_ack),
        .i_SrcW     (i_SrcW),
        .SrcI_rdy   (SrcI_rdy),
        .SrcI_ack   (SrcI_ack),
        .i_SrcI     (i_SrcI),
        .Weight_rdy (Weight_rdy),
        .Weight_ack (Weight_ack),
        .o_Weight   (o_Weight),
        .Input_rdy  (Input_rdy),
        .Input_ack  (Input_ack),
        .o_Input    (o_Input),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;
    int ws_idx   = 1;
    int is_idx   = 1;

    typedef struct {
        logic       cr;
        logic [7:0] nw;
        logic [7:0] ni;
        logic       swr;
        logic       sir;
        logic       wa;
        logic       ia;
        logic       e_cack;
        logic       e_swack;
        logic       e_siack;
        logic       e_wrdy;
        int         e_widx;
        logic       e_irdy;
        int         e_iidx;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tbl[$];

    // Source vector k (counted from 1 within a job): word j = k + 256*j.
    function automatic logic [63:0] wvec(input int k);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < PECOL; j++) v[j*16 +: 16] = 16'(k + 256 * j);
        return v;
    endfunction

    function automatic logic [63:0] ivec(input int k);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < IPADN; j++) v[j*16 +: 16] = 16'(32'h1000 + k + 256 * j);
        return v;
    endfunction

    function automatic void addv(input logic cr, input logic [7:0] nw, input logic [7:0] ni,
                                 input logic swr, input logic sir, input logic wa, input logic ia,
                                 input logic e_cack, input logic e_swack, input logic e_siack,
                                 input logic e_wrdy, input int e_widx,
                                 input logic e_irdy, input int e_iidx,
                                 input logic e_busy, input logic e_done);
        vec_t v;
        v.cr = cr; v.nw = nw; v.ni = ni; v.swr = swr; v.sir = sir; v.wa = wa; v.ia = ia;
        v.e_cack = e_cack; v.e_swack = e_swack; v.e_siack = e_siack;
        v.e_wrdy = e_wrdy; v.e_widx = e_widx; v.e_irdy = e_irdy; v.e_iidx = e_iidx;
        v.e_busy = e_busy; v.e_done = e_done;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_sources();
        i_SrcW = wvec(ws_idx)[DWD*PECOL-1:0];
        i_SrcI = ivec(is_idx)[DWD*IPADN-1:0];
    endtask

    // Advance the source model after the clock edge that completed a cycle.
    task automatic advance(input bit cx, input bit wx, input bit ix);
        if (cx) begin
            ws_idx = 1;
            is_idx = 1;
        end
        if (wx) ws_idx++;
        if (ix) is_idx++;
        drive_sources();
    endtask

    task automatic run_table();
        vec_t v;
        bit   cx, wx, ix;
        for (int k = 0; k < tbl.size(); k++) begin
            v = tbl[k];
            Cmd_rdy    = v.cr;
            i_cmd      = {v.nw, v.ni};
            SrcW_rdy   = v.swr;
            SrcI_rdy   = v.sir;
            Weight_ack = v.wa;
            Input_ack  = v.ia;
            drive_sources();
            @(negedge i_clk);
            chk($sformatf("row%0d Cmd_ack", k),    64'(Cmd_ack),    64'(v.e_cack));
            chk($sformatf("row%0d SrcW_ack", k),   64'(SrcW_ack),   64'(v.e_swack));
            chk($sformatf("row%0d SrcI_ack", k),   64'(SrcI_ack),   64'(v.e_siack));
            chk($sformatf("row%0d Weight_rdy", k), 64'(Weight_rdy), 64'(v.e_wrdy));
            chk($sformatf("row%0d Input_rdy", k),  64'(Input_rdy),  64'(v.e_irdy));
            chk($sformatf("row%0d o_busy", k),     64'(o_busy),     64'(v.e_busy));
            chk($sformatf("row%0d o_done", k),     64'(o_done),     64'(v.e_done));
            if (v.e_widx != 0) chk($sformatf("row%0d o_Weight", k), 64'(o_Weight), wvec(v.e_widx));
            if (v.e_iidx != 0) chk($sformatf("row%0d o_Input", k),  64'(o_Input),  ivec(v.e_iidx));
            cx = Cmd_rdy && Cmd_ack;
            wx = SrcW_rdy && SrcW_ack;
            ix = SrcI_rdy && SrcI_ack;
            @(posedge i_clk);
            #1;
            advance(cx, wx, ix);
        end
    endtask

    // Issue one job with everything ready; optionally assert reset right
    // after the PE has taken rst_after_w weight vectors.
    task automatic run_job(input logic [7:0] nw, input logic [7:0] ni, input int rst_after_w);
        int pe_w, pe_i;
        bit got_done, aborted, cx, wx, ix;
        pe_w = 0; pe_i = 0; got_done = 0; aborted = 0;
        Cmd_rdy = 1'b1; i_cmd = {nw, ni};
        SrcW_rdy = 1'b1; SrcI_rdy = 1'b1; Weight_ack = 1'b1; Input_ack = 1'b1;
        drive_sources();
        for (int cyc = 0; cyc < 60 && !got_done && !aborted; cyc++) begin
            @(negedge i_clk);
            cx = Cmd_rdy && Cmd_ack;
            wx = SrcW_rdy && SrcW_ack;
            ix = SrcI_rdy && SrcI_ack;
            if (Weight_rdy && Weight_ack) begin
                pe_w++;
                chk($sformatf("job w%0d data", pe_w), 64'(o_Weight), wvec(pe_w));
            end
            if (Input_rdy && Input_ack) begin
                pe_i++;
                chk($sformatf("job i%0d data", pe_i), 64'(o_Input), ivec(pe_i));
            end
            if (o_done) got_done = 1;
            @(posedge i_clk);
            #1;
            if (cx) Cmd_rdy = 1'b0;
            advance(cx, wx, ix);
            if (rst_after_w > 0 && pe_w == rst_after_w) begin
                i_rst   = 1'b1;
                aborted = 1;
            end
        end
        if (rst_after_w > 0) begin
            chk("abort reached", 64'(aborted), 64'd1);
            chk("abort no done", 64'(got_done), 64'd0);
            @(negedge i_clk);
            chk("abort Weight_rdy", 64'(Weight_rdy), 64'd0);
            chk("abort Input_rdy",  64'(Input_rdy),  64'd0);
            chk("abort o_busy",     64'(o_busy),     64'd0);
            chk("abort Cmd_ack",    64'(Cmd_ack),    64'd1);
            chk("abort SrcW_ack",   64'(SrcW_ack),   64'd0);
            chk("abort o_Weight",   64'(o_Weight),   64'd0);
            @(posedge i_clk);
            #1;
            i_rst = 1'b0;
        end else begin
            chk("job done seen", 64'(got_done), 64'd1);
            chk("job weight count", 64'(pe_w), 64'(nw));
            chk("job input count",  64'(pe_i), 64'(ni));
        end
    endtask

    initial begin
        i_rst = 1'b1;
        Cmd_rdy = 1'b0; i_cmd = '0;
        SrcW_rdy = 1'b0; SrcI_rdy = 1'b0;
        Weight_ack = 1'b0; Input_ack = 1'b0;
        drive_sources();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst Cmd_ack",    64'(Cmd_ack),    64'd1);
        chk("rst SrcW_ack",   64'(SrcW_ack),   64'd0);
        chk("rst SrcI_ack",   64'(SrcI_ack),   64'd0);
        chk("rst Weight_rdy", 64'(Weight_rdy), 64'd0);
        chk("rst Input_rdy",  64'(Input_rdy),  64'd0);
        chk("rst o_busy",     64'(o_busy),     64'd0);
        chk("rst o_done",     64'(o_done),     64'd0);
        chk("rst o_Weight",   64'(o_Weight),   64'd0);
        chk("rst o_Input",    64'(o_Input),    64'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

`ifdef PE_FEEDER_OVERLAP_EN
        // nw=3, ni=3: both channels move in the same cycles
        addv(1, 3, 3, 1, 1, 1, 1,  1, 0, 0,  0, 0, 0, 0,  0, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 1, 1,  0, 0, 0, 0,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 1, 1,  1, 1, 1, 1,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 1, 1,  1, 2, 1, 2,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 0,  1, 3, 1, 3,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0,  1, 1);
        addv(0, 0, 0, 1, 1, 1, 1,  1, 0, 0,  0, 0, 0, 0,  0, 0);
`else
        // Job A: nw=2, ni=3, everything ready
        addv(1, 2, 3, 1, 1, 1, 1,  1, 0, 0,  0, 0, 0, 0,  0, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 1, 0,  0, 0, 0, 0,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 1, 0,  1, 1, 0, 0,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 0,  1, 2, 0, 0,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 1,  0, 0, 0, 0,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 1,  0, 0, 1, 1,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 1,  0, 0, 1, 2,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 0,  0, 0, 1, 3,  1, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0,  1, 1);
        // Job B: nw=0, ni=0 -> done right after acceptance
        addv(1, 0, 0, 1, 1, 1, 1,  1, 0, 0,  0, 0, 0, 0,  0, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0,  1, 1);
        // Job C: nw=4, Weight_ack toggling, a second command held meanwhile
        addv(1, 4, 0, 1, 1, 0, 1,  1, 0, 0,  0, 0, 0, 0,  0, 0);
        addv(1, 7, 0, 1, 1, 1, 1,  0, 1, 0,  0, 0, 0, 0,  1, 0);
        addv(1, 7, 0, 1, 1, 0, 1,  0, 0, 0,  1, 1, 0, 0,  1, 0);
        addv(1, 7, 0, 1, 1, 1, 1,  0, 1, 0,  1, 1, 0, 0,  1, 0);
        addv(1, 7, 0, 1, 1, 0, 1,  0, 0, 0,  1, 2, 0, 0,  1, 0);
        addv(1, 7, 0, 1, 1, 1, 1,  0, 1, 0,  1, 2, 0, 0,  1, 0);
        addv(1, 7, 0, 1, 1, 0, 1,  0, 0, 0,  1, 3, 0, 0,  1, 0);
        addv(1, 7, 0, 1, 1, 1, 1,  0, 1, 0,  1, 3, 0, 0,  1, 0);
        addv(1, 7, 0, 1, 1, 0, 1,  0, 0, 0,  1, 4, 0, 0,  1, 0);
        addv(1, 7, 0, 1, 1, 1, 1,  0, 0, 0,  1, 4, 0, 0,  1, 0);
        addv(1, 7, 0, 1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0,  1, 1);
        // held command finally taken two cycles after the last PE transfer
        addv(1, 0, 0, 1, 1, 1, 1,  1, 0, 0,  0, 0, 0, 0,  0, 0);
        addv(0, 0, 0, 1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0,  1, 1);
        addv(0, 0, 0, 1, 1, 1, 1,  1, 0, 0,  0, 0, 0, 0,  0, 0);
`endif
        run_table();

        // reset after the 2nd of 5 weight transfers, then a clean job
        run_job(8'd5, 8'd1, 2);
        run_job(8'd1, 8'd1, 0);
        run_job(8'd3, 8'd2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
